// File: rtl/frame_ingress_fifo.sv
// -----------------------------------------------------------------------------
// frame_ingress_fifo
//   Store-and-forward ingress buffer between the MAC Avalon-ST receive stream
//   and the sniffer controller. Words of a frame are written as they arrive,
//   but only become readable once the frame's eop word has been accepted
//   without an error. Bad, truncated or oversize frames are rewound and never
//   reach the reader.
//
// Optional feature macro: STATS_EN
//   defined   : frames_ok / frames_drop saturating 16-bit counters are built
//   undefined : frames_ok / frames_drop are tied to 0
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_data/in_valid/in_sop/
//   in_eop/in_error/in_ready  MAC receive stream (accept = in_valid & in_ready)
//   rdreq                     controller read request
//   rd_data/rd_sop/rd_eop     read word, valid while shift_enable = 1
//   shift_enable              one-cycle strobe, read word presented
//   frame_avail               at least one committed word is unread
//   eop                       one-cycle pulse: a frame ended (kept or dropped)
//   error                     one-cycle pulse: the current frame was dropped
//   frames_ok, frames_drop    committed / dropped frame counters
//
// Handshake: a write happens on a rising edge where in_valid and in_ready are
// both 1; in_ready depends only on registered state. A read happens on a
// rising edge where rdreq and frame_avail are both 1; the word appears on
// rd_data in the following cycle together with shift_enable.
// -----------------------------------------------------------------------------
module frame_ingress_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_error,
  output logic              in_ready,
  input  logic              rdreq,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_sop,
  output logic              rd_eop,
  output logic              shift_enable,
  output logic              frame_avail,
  output logic              eop,
  output logic              error,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_drop
);

  localparam logic [1:0] ST_WAIT_SOP = 2'd0;
  localparam logic [1:0] ST_RECEIVE  = 2'd1;
  localparam logic [1:0] ST_DROP     = 2'd2;

  // Storage word layout: {sop, eop, data}
  logic [DATA_W+1:0] mem [DEPTH];

  logic [1:0]      state, state_nx;
  logic [ADDR_W:0] wr_ptr, wr_ptr_nx;
  logic [ADDR_W:0] commit_ptr, commit_nx;
  logic [ADDR_W:0] frame_start, fstart_nx;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_addr;
  logic            wr_en;
  logic            eop_nx;
  logic            err_nx;
  logic            commit_ev;
  logic            full;
  logic            accept;
  logic            rd_en;

  // Pointers carry a wrap bit: equal index with differing wrap bit means full.
  assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign in_ready    = (state == ST_RECEIVE) ? !full : 1'b1;
  assign accept      = in_valid && in_ready;
  assign frame_avail = (rd_ptr != commit_ptr);
  assign rd_en       = rdreq && frame_avail;

  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    commit_nx = commit_ptr;
    fstart_nx = frame_start;
    wr_addr   = wr_ptr;
    wr_en     = 1'b0;
    eop_nx    = 1'b0;
    err_nx    = 1'b0;
    commit_ev = 1'b0;
    case (state)
      ST_WAIT_SOP: begin
        // Words without sop are silently discarded here.
        if (accept && in_sop) begin
          // in_ready stays high in this state, so a start word that arrives
          // while committed data fills the buffer cannot be stored without
          // overwriting unread words: that frame is dropped instead.
          if (in_error || full) begin
            err_nx = 1'b1;
            if (in_eop) eop_nx = 1'b1;
            else        state_nx = ST_DROP;
          end else begin
            fstart_nx = wr_ptr;
            wr_en     = 1'b1;
            wr_ptr_nx = wr_ptr + 1'b1;
            if (in_eop) begin
              commit_nx = wr_ptr + 1'b1;
              eop_nx    = 1'b1;
              commit_ev = 1'b1;
            end else begin
              state_nx = ST_RECEIVE;
            end
          end
        end
      end
      ST_RECEIVE: begin
        if (full && (commit_ptr == rd_ptr)) begin
          // The open frame alone fills the buffer and nothing can drain.
          wr_ptr_nx = frame_start;
          err_nx    = 1'b1;
          state_nx  = ST_DROP;
        end else if (accept) begin
          if (in_error) begin
            wr_ptr_nx = frame_start;
            err_nx    = 1'b1;
            if (in_eop) begin
              eop_nx   = 1'b1;
              state_nx = ST_WAIT_SOP;
            end else begin
              state_nx = ST_DROP;
            end
          end else if (in_sop) begin
            // Old frame is abandoned; the new frame reuses its start slot.
            err_nx    = 1'b1;
            wr_addr   = frame_start;
            wr_en     = 1'b1;
            wr_ptr_nx = frame_start + 1'b1;
            if (in_eop) begin
              commit_nx = frame_start + 1'b1;
              eop_nx    = 1'b1;
              commit_ev = 1'b1;
              state_nx  = ST_WAIT_SOP;
            end
          end else begin
            wr_en     = 1'b1;
            wr_ptr_nx = wr_ptr + 1'b1;
            if (in_eop) begin
              commit_nx = wr_ptr + 1'b1;
              eop_nx    = 1'b1;
              commit_ev = 1'b1;
              state_nx  = ST_WAIT_SOP;
            end
          end
        end
      end
      ST_DROP: begin
        if (accept && in_eop) begin
          eop_nx   = 1'b1;
          state_nx = ST_WAIT_SOP;
        end
      end
      default: state_nx = ST_WAIT_SOP;
    endcase
  end

  // RAM array has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[ADDR_W-1:0]] <= {in_sop, in_eop, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_WAIT_SOP;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      frame_start <= '0;
      rd_ptr      <= '0;
      eop         <= 1'b0;
      error       <= 1'b0;
      shift_enable <= 1'b0;
      rd_data     <= '0;
      rd_sop      <= 1'b0;
      rd_eop      <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_ptr      <= wr_ptr_nx;
      commit_ptr  <= commit_nx;
      frame_start <= fstart_nx;
      eop         <= eop_nx;
      error       <= err_nx;
      shift_enable <= rd_en;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        {rd_sop, rd_eop, rd_data} <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

`ifdef STATS_EN
  logic [15:0] stat_ok, stat_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ok   <= '0;
      stat_drop <= '0;
    end else begin
      if (commit_ev && (stat_ok != 16'hFFFF))  stat_ok   <= stat_ok + 16'd1;
      if (err_nx && (stat_drop != 16'hFFFF))   stat_drop <= stat_drop + 16'd1;
    end
  end

  assign frames_ok   = stat_ok;
  assign frames_drop = stat_drop;
`else
  logic unused_commit_ev;
  assign unused_commit_ev = commit_ev;
  assign frames_ok   = '0;
  assign frames_drop = '0;
`endif

endmodule

// File: tb/tb_frame_ingress_fifo.sv
// Bench for frame_ingress_fifo (DATA_W=32, DEPTH=16).
// Stimulus pushes expected read words into exp_q and expected pulse events
// ({error,eop}) into ev_q; a monitor pops and compares whenever the DUT
// presents shift_enable or an eop/error pulse.
module tb_frame_ingress_fifo;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              in_error = 1'b0;
  logic              in_ready;
  logic              rdreq = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_sop, rd_eop, shift_enable, frame_avail, eop, error;
  logic [15:0]       frames_ok, frames_drop;

  int checks = 0;
  int failures = 0;

  logic [DATA_W+1:0] exp_q[$];
  logic [1:0]        ev_q[$];

`ifdef STATS_EN
  localparam logic [15:0] EXP_OK   = 16'd7;
  localparam logic [15:0] EXP_DROP = 16'd3;
`else
  localparam logic [15:0] EXP_OK   = 16'd0;
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  frame_ingress_fifo #(.DATA_W(DATA_W), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_error(in_error), .in_ready(in_ready),
    .rdreq(rdreq), .rd_data(rd_data), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .shift_enable(shift_enable), .frame_avail(frame_avail),
    .eop(eop), .error(error),
    .frames_ok(frames_ok), .frames_drop(frames_drop)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (shift_enable) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual=%0h required=none", {rd_sop, rd_eop, rd_data});
        end else begin
          check("rd_word", {rd_sop, rd_eop, rd_data}, exp_q.pop_front());
        end
      end
      if (eop || error) begin
        if (ev_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL pulse_unexpected actual=%0b required=none", {error, eop});
        end else begin
          check("pulse", {error, eop}, ev_q.pop_front());
        end
      end
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic send_word(input logic [DATA_W-1:0] d, input logic s, input logic e,
                           input logic er);
    int guard;
    guard = 0;
    in_data = d; in_sop = s; in_eop = e; in_error = er; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
  endtask

  // err_at < 0 means no error; keep=1 pushes the words as expected reads.
  task automatic send_frame(input logic [DATA_W-1:0] base, input int len,
                            input int err_at, input bit keep);
    for (int i = 0; i < len; i++) begin
      logic s, e;
      logic [DATA_W-1:0] d;
      s = (i == 0);
      e = (i == len - 1);
      d = base + DATA_W'(i);
      if (keep) exp_q.push_back({s, e, d});
      send_word(d, s, e, (i == err_at));
    end
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      rdreq = 1'b1;
      @(negedge clk);
    end
    rdreq = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_avail", frame_avail, 0);
    check("rst_shift_enable", shift_enable, 0);
    check("rst_eop", eop, 0);
    check("rst_error", error, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frames_ok", frames_ok, 0);
    check("rst_frames_drop", frames_drop, 0);
    rst = 1'b0;
    @(negedge clk);

    // 4-word good frame, then read it back
    ev_q.push_back(2'b01);
    send_frame(32'hA000_0000, 4, -1, 1'b1);
    check("good_avail", frame_avail, 1);
    read_n(4);
    @(negedge clk);
    check("good_drained", frame_avail, 0);

    // 6-word frame with error on word 3
    ev_q.push_back(2'b10);
    ev_q.push_back(2'b01);
    send_frame(32'hB000_0000, 6, 2, 1'b0);
    check("err_avail", frame_avail, 0);

    // Words without sop while waiting for a frame start
    send_word(32'hC000_0001, 1'b0, 1'b0, 1'b0);
    send_word(32'hC000_0002, 1'b0, 1'b1, 1'b0);
    send_word(32'hC000_0003, 1'b0, 1'b0, 1'b1);
    check("nosop_avail", frame_avail, 0);

    // Oversize 20-word frame with no reads
    for (int i = 0; i < 16; i++)
      send_word(32'hD000_0000 + DATA_W'(i), (i == 0), 1'b0, 1'b0);
    check("full_in_ready", in_ready, 0);
    ev_q.push_back(2'b10);
    ev_q.push_back(2'b01);
    for (int i = 16; i < 20; i++)
      send_word(32'hD000_0000 + DATA_W'(i), 1'b0, (i == 19), 1'b0);
    check("oversize_avail", frame_avail, 0);
    // Next good frame after the oversize drop
    ev_q.push_back(2'b01);
    send_frame(32'hE000_0000, 3, -1, 1'b1);
    check("after_over_avail", frame_avail, 1);
    read_n(3);

    // Frame A committed, frame B streams in while A is read each cycle
    ev_q.push_back(2'b01);
    send_frame(32'h1A00_0000, 12, -1, 1'b1);
    ev_q.push_back(2'b01);
    fork
      send_frame(32'h1B00_0000, 10, -1, 1'b1);
      begin
        repeat (6) @(negedge clk);
        read_n(30);
      end
    join
    check("stream_drained", frame_avail, 0);

    // Single-word frame
    ev_q.push_back(2'b01);
    exp_q.push_back({1'b1, 1'b1, 32'h5151_5151});
    send_word(32'h5151_5151, 1'b1, 1'b1, 1'b0);
    read_n(1);

    // Mid-frame sop: old frame dropped, new frame kept
    ev_q.push_back(2'b10);
    ev_q.push_back(2'b01);
    send_word(32'h7700_0000, 1'b1, 1'b0, 1'b0);
    send_word(32'h7700_0001, 1'b0, 1'b0, 1'b0);
    send_word(32'h7700_0002, 1'b0, 1'b0, 1'b0);
    send_frame(32'h8800_0000, 2, -1, 1'b1);
    read_n(2);

    // Committed frame left unread, open frame, then reset mid-frame
    ev_q.push_back(2'b01);
    send_frame(32'h9900_0000, 2, -1, 1'b0);
    @(negedge clk);
    check("stats_ok", frames_ok, EXP_OK);
    check("stats_drop", frames_drop, EXP_DROP);
    send_word(32'h9A00_0000, 1'b1, 1'b0, 1'b0);
    send_word(32'h9A00_0001, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_avail", frame_avail, 0);
    check("midrst_ok", frames_ok, 0);
    check("midrst_drop", frames_drop, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Function after reset
    ev_q.push_back(2'b01);
    send_frame(32'hF000_0000, 2, -1, 1'b1);
    read_n(2);
    repeat (4) @(negedge clk);
    check("final_avail", frame_avail, 0);
    check("exp_q_empty", exp_q.size(), 0);
    check("ev_q_empty", ev_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
